// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-locked round-robin merge of
// NUM_SRC AXI-Stream sources onto one downstream channel.

package pp_package;
  localparam int TDATA_WIDTH = 32;
  localparam int TUSER_WIDTH = 4;
endpackage

module axis_pkt_arbiter
  import pp_package::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  s_tvalid,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]      s_tdata,
  input  logic [NUM_SRC-1:0]                  s_tlast,
  input  logic [NUM_SRC*(TDATA_WIDTH/8)-1:0]  s_tstrb,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]      s_tuser,
  output logic [NUM_SRC-1:0]                  s_tready,
  output logic                                m_tvalid,
  output logic [TDATA_WIDTH-1:0]              m_tdata,
  output logic                                m_tlast,
  output logic [TDATA_WIDTH/8-1:0]            m_tstrb,
  output logic [TUSER_WIDTH-1:0]              m_tuser,
  input  logic                                m_tready,
  output logic [IDX_W-1:0]                    grant_idx,
  output logic                                busy
);

  localparam int TW = TDATA_WIDTH;
  localparam int SW = TDATA_WIDTH / 8;
  localparam int UW = TUSER_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   cand;
  logic             found;

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Search from rr_ptr, mux the locked source, decide next state
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tstrb  = '0;
    m_tuser  = '0;
    found    = 1'b0;
    win      = '0;
    cand     = '0;

    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_SRC))
        cand = cand - (IDX_W+1)'(NUM_SRC);
      if (!found && s_tvalid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        m_tvalid = s_tvalid[grant_q];
        m_tlast  = s_tlast[grant_q];
        m_tdata  = s_tdata[int'(grant_q)*TW +: TW];
        m_tstrb  = s_tstrb[int'(grant_q)*SW +: SW];
        m_tuser  = s_tuser[int'(grant_q)*UW +: UW];
        s_tready[grant_q] = m_tready;
        if (m_tvalid && m_tready && m_tlast) begin
          state_d = IDLE;
          if (grant_q == IDX_W'(NUM_SRC-1))
            rr_ptr_d = '0;
          else
            rr_ptr_d = grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed scoreboard bench for
// the packet round-robin arbiter.

module tb_axis_pkt_arbiter;
  import pp_package::*;

  localparam int NS = 4;
  localparam int TW = TDATA_WIDTH;
  localparam int SW = TDATA_WIDTH / 8;
  localparam int UW = TUSER_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     s_tvalid;
  logic [NS*TW-1:0]  s_tdata;
  logic [NS-1:0]     s_tlast;
  logic [NS*SW-1:0]  s_tstrb;
  logic [NS*UW-1:0]  s_tuser;
  logic [NS-1:0]     s_tready;
  logic              m_tvalid;
  logic [TW-1:0]     m_tdata;
  logic              m_tlast;
  logic [SW-1:0]     m_tstrb;
  logic [UW-1:0]     m_tuser;
  logic              m_tready;
  logic [1:0]        grant_idx;
  logic              busy;

  logic              vld [NS];
  logic              lst [NS];
  logic [TW-1:0]     dat [NS];

  typedef struct {
    int          src;
    logic [31:0] data;
    logic        last;
    int          gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  axis_pkt_arbiter #(.NUM_SRC(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tstrb   (s_tstrb),
    .s_tuser   (s_tuser),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tstrb   (m_tstrb),
    .m_tuser   (m_tuser),
    .m_tready  (m_tready),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]           = vld[i];
      s_tlast[i]            = lst[i];
      s_tdata[i*TW +: TW]   = dat[i];
      s_tstrb[i*SW +: SW]   = dat[i][3:0];
      s_tuser[i*UW +: UW]   = ~dat[i][3:0];
    end
  end

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void push(int src, logic [7:0] d,
                               logic l, int gap);
    exp_t e;
    e.src  = src;
    e.data = 32'(d);
    e.last = l;
    e.gap  = gap;
    sb.push_back(e);
  endfunction

  // monitor: handshake rules every cycle, beats against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (busy) begin
        check("rdy_excl",
              32'(s_tready & ~(4'b0001 << grant_idx)), 32'd0);
        check("rdy_grant",
              32'(s_tready[grant_idx]), 32'(m_tready));
      end else begin
        check("idle_quiet", 32'({s_tready, m_tvalid}), 32'd0);
      end
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL extra_beat: got %h want none", m_tdata);
        end else begin
          mon_e = sb.pop_front();
          check("beat_data", m_tdata, mon_e.data);
          check("beat_last", 32'(m_tlast), 32'(mon_e.last));
          check("beat_grant", 32'(grant_idx), 32'(mon_e.src));
          check("beat_strb", 32'(m_tstrb), 32'(mon_e.data[3:0]));
          check("beat_user", 32'(m_tuser),
                32'(4'(~mon_e.data[3:0])));
          if (mon_e.gap != 0)
            check("beat_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic send_pkt(input int src, input int n,
                          input logic [7:0] base,
                          input int gap_at);
    int t;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        vld[src] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      vld[src] = 1'b1;
      dat[src] = 32'(base) + 32'(b);
      lst[src] = (b == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_tready[src] && t < 200);
      if (!s_tready[src]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got src %0d stalled want handshake", src);
        vld[src] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    vld[src] = 1'b0;
    lst[src] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_reset_outs(string nm);
    check({nm, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_grant"}, 32'(grant_idx), 32'd0);
    check({nm, "_tready"}, 32'(s_tready), 32'd0);
    check({nm, "_mout"},
          32'({m_tdata, m_tlast, m_tstrb, m_tuser} != '0), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      vld[i] = 1'b0;
      lst[i] = 1'b0;
      dat[i] = '0;
    end
    m_tready = 1'b1;
    rst = 1'b0;
    #2;
    check_reset_outs("rst0");
    check("rst0_rrptr", 32'(dut.rr_ptr_q), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // single source 2, three beats
    push(2, 8'hA1, 1'b0, 0);
    push(2, 8'hA2, 1'b0, 1);
    push(2, 8'hA3, 1'b1, 1);
    send_pkt(2, 3, 8'hA1, -1);
    check("single_busy", 32'(busy), 32'd0);
    check("single_rrptr", 32'(dut.rr_ptr_q), 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // contention from reset: 0 then 1
    do_reset();
    push(0, 8'h10, 1'b0, 0);
    push(0, 8'h11, 1'b1, 1);
    push(1, 8'h20, 1'b0, 2);
    push(1, 8'h21, 1'b1, 1);
    fork
      send_pkt(0, 2, 8'h10, -1);
      send_pkt(1, 2, 8'h20, -1);
    join
    check("cont_rrptr", 32'(dut.rr_ptr_q), 32'd2);
    repeat (2) @(posedge clk);
    #1;

    // full rotation, single-beat packets
    do_reset();
    push(0, 8'h00, 1'b1, 0);
    push(1, 8'h10, 1'b1, 2);
    push(2, 8'h20, 1'b1, 2);
    push(3, 8'h30, 1'b1, 2);
    push(0, 8'h01, 1'b1, 2);
    push(1, 8'h11, 1'b1, 2);
    fork
      begin
        send_pkt(0, 1, 8'h00, -1);
        send_pkt(0, 1, 8'h01, -1);
      end
      begin
        send_pkt(1, 1, 8'h10, -1);
        send_pkt(1, 1, 8'h11, -1);
      end
      send_pkt(2, 1, 8'h20, -1);
      send_pkt(3, 1, 8'h30, -1);
    join
    repeat (2) @(posedge clk);
    #1;
    check("rot_rrptr", 32'(dut.rr_ptr_q), 32'd2);

    // backpressure and source gap on source 3
    push(3, 8'h30, 1'b0, 0);
    push(3, 8'h31, 1'b0, 3);
    push(3, 8'h32, 1'b0, 3);
    push(3, 8'h33, 1'b1, 1);
    fork
      send_pkt(3, 4, 8'h30, 2);
      begin
        int t;
        logic [3:0] pat;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!busy && t < 50);
        check("bp_grant", 32'(grant_idx), 32'd3);
        pat = 4'b1001;
        for (int k = 3; k >= 0; k--) begin
          m_tready = pat[k];
          if (!pat[k]) begin
            @(negedge clk);
            check("bp_hold", m_tdata, 32'h31);
          end
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
        @(negedge clk);
        check("bp_lock",
              32'({busy, grant_idx, m_tvalid}), 32'b1_11_0);
      end
    join
    check("bp_busy", 32'(busy), 32'd0);
    check("bp_rrptr", 32'(dut.rr_ptr_q), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset mid-packet from source 1
    push(1, 8'h50, 1'b0, 0);
    vld[1] = 1'b1;
    lst[1] = 1'b0;
    dat[1] = 32'h50;
    begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_tready[1] && t < 50);
      check("rm_grant", 32'(s_tready[1]), 32'd1);
    end
    @(posedge clk);
    #1;
    dat[1] = 32'h51;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("rm");
    check("rm_rrptr", 32'(dut.rr_ptr_q), 32'd0);
    vld[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, 8'h60, 1'b1, 0);
    push(1, 8'h70, 1'b1, 2);
    fork
      send_pkt(0, 1, 8'h60, -1);
      send_pkt(1, 1, 8'h70, -1);
    join

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
